mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameters: XLEN, default 32, data/address width; MAX_DRUN, default 4, max consecutive data grants while an instruction request waits.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 i_ireq  input  1  instruction fetch request; held stable until o_ivalid.
REQ-005 i_iaddr  input  XLEN  fetch byte address.
REQ-006 o_inst  output  XLEN  fetched word; valid only when o_ivalid.
REQ-007 o_ivalid  output  1  one-cycle pulse, fetch complete.
REQ-008 i_dren / i_dwen  input  1 each  data read / write request; mutually exclusive; held stable until o_dvalid.
REQ-009 i_daddr  input  XLEN  data byte address; i_dwdata  input  XLEN  store data.
REQ-010 o_drdata  output  XLEN  load data; o_dvalid  output  1  one-cycle pulse, data access complete.
REQ-011 o_exstall  output  1  stall to core (drives core i_exstall).
REQ-012 o_mreq  output  1  memory request; o_mwe  output  1  write strobe; o_maddr  output  XLEN; o_mwdata  output  XLEN.
REQ-013 i_mack  input  1  memory completion pulse; i_mrdata  input  XLEN  read data valid with i_mack.

Function
REQ-014 FSM states: IDLE, IGRANT, DGRANT; owner encoded by state.
REQ-015 IDLE: if data request pending and (no instruction request or drun < MAX_DRUN) -> DGRANT; else if instruction request pending -> IGRANT; else stay.
REQ-016 On entering a GRANT state, o_mreq, o_mwe, o_maddr, o_mwdata are registered from the granted requester and held constant until i_mack.
REQ-017 Grant-to-o_mreq latency: o_mreq high the cycle after the request is sampled in IDLE.
REQ-018 On i_mack in IGRANT: o_inst <= i_mrdata, o_ivalid pulses next cycle, o_mreq drops, state -> IDLE.
REQ-019 On i_mack in DGRANT: o_drdata <= i_mrdata (reads only; unchanged for writes), o_dvalid pulses next cycle, state -> IDLE.
REQ-020 Requester whose valid pulse is high is not re-granted in that same cycle; re-arbitration uses the following cycle's requests.
REQ-021 drun counter: increments on each DGRANT entry while i_ireq high, clears on IGRANT entry or when i_ireq low; saturates at MAX_DRUN.
REQ-022 i_mack asserted in IDLE is ignored; no state or output change.
REQ-023 i_mack same cycle as o_mreq first asserted completes the transaction (zero-wait memory allowed).
REQ-024 o_exstall = (i_dren | i_dwen) & ~o_dvalid, combinational, so the core stalls from request until completion.
REQ-025 Address passed unmodified; word alignment is the memory's concern.
REQ-026 Back-to-back: minimum 3 cycles per transaction with zero-wait memory (grant, ack, valid).

Reset
REQ-027 When rst high at a clock edge: state <= IDLE, drun <= 0, o_mreq <= 0, o_mwe <= 0, o_ivalid <= 0, o_dvalid <= 0, o_inst <= 0, o_drdata <= 0, o_maddr <= 0, o_mwdata <= 0.
REQ-028 Reset mid-transaction abandons it; no valid pulse issued; a later stray i_mack is ignored per REQ-022.

Structure
REQ-029 FSM state encoding and MAX_DRUN default live in a shared package/include header used by core-level integration.
REQ-030 Single flat module; no sub-modules required; arbitration decision may be a separate function.

Verification
REQ-031 Idle fetch: i_ireq=1, i_iaddr=0x100, memory acks 1 cycle after o_mreq with 0x00000013 -> o_maddr=0x100, o_mwe=0, o_inst=0x00000013, single o_ivalid pulse.
REQ-032 Store: i_dwen=1, i_daddr=0x2000, i_dwdata=0xDEADBEEF -> o_mwe=1, o_mwdata=0xDEADBEEF, o_exstall high until o_dvalid, o_drdata unchanged.
REQ-033 Contention: i_ireq and i_dren asserted continuously, zero-wait memory -> grant order D,D,D,D,I,D,D,D,D,I (MAX_DRUN=4).
REQ-034 Simultaneous i_ireq and i_dren from IDLE, drun=0 -> data granted first; fetch completes after o_dvalid.
REQ-035 rst asserted while o_mreq high in DGRANT, i_mack arrives 2 cycles after reset release -> no o_dvalid, all outputs 0, state IDLE.
REQ-036 Stray i_mack with no request -> no valid pulses, o_mreq stays 0.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the instruction/data memory arbiter: state encoding,
// default parameters and the arbitration decision used when the bus is idle.
package mem_arbiter_pkg;

  localparam int DEF_XLEN     = 32;
  localparam int DEF_MAX_DRUN = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_IGRANT = 2'd1,
    ST_DGRANT = 2'd2
  } arb_state_t;

  // Data wins unless it has already starved a waiting fetch for MAX_DRUN grants.
  function automatic arb_state_t arb_pick(input logic dreq, input logic ireq,
                                          input logic drun_ok);
    arb_state_t res;
    res = ST_IDLE;
    if (dreq && (!ireq || drun_ok)) res = ST_DGRANT;
    else if (ireq)                  res = ST_IGRANT;
    return res;
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of core-side request/response and memory-side bus signals of the arbiter.
// Requests (i_ireq, i_dren/i_dwen) are held stable until their one-cycle o_*valid
// pulse; o_mreq and its address/data/strobe stay constant until the i_mack pulse.
interface mem_arbiter_if #(
  parameter int XLEN = mem_arbiter_pkg::DEF_XLEN
);

  logic            i_ireq;
  logic [XLEN-1:0] i_iaddr;
  logic [XLEN-1:0] o_inst;
  logic            o_ivalid;
  logic            i_dren;
  logic            i_dwen;
  logic [XLEN-1:0] i_daddr;
  logic [XLEN-1:0] i_dwdata;
  logic [XLEN-1:0] o_drdata;
  logic            o_dvalid;
  logic            o_exstall;
  logic            o_mreq;
  logic            o_mwe;
  logic [XLEN-1:0] o_maddr;
  logic [XLEN-1:0] o_mwdata;
  logic            i_mack;
  logic [XLEN-1:0] i_mrdata;

  modport slave (
    input  i_ireq, i_iaddr, i_dren, i_dwen, i_daddr, i_dwdata, i_mack, i_mrdata,
    output o_inst, o_ivalid, o_drdata, o_dvalid, o_exstall,
           o_mreq, o_mwe, o_maddr, o_mwdata
  );

  modport master (
    output i_ireq, i_iaddr, i_dren, i_dwen, i_daddr, i_dwdata, i_mack, i_mrdata,
    input  o_inst, o_ivalid, o_drdata, o_dvalid, o_exstall,
           o_mreq, o_mwe, o_maddr, o_mwdata
  );

endinterface

// File: rtl/mem_arbiter.sv
// Arbitrates a single memory port between instruction fetch and data access,
// favouring data but forcing a fetch after MAX_DRUN consecutive data grants.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int XLEN     = DEF_XLEN,
  parameter int MAX_DRUN = DEF_MAX_DRUN
) (
  input  logic          clk,
  input  logic          rst,
  mem_arbiter_if.slave  bus,
  output arb_state_t    o_state
);

  localparam int                DRUN_W   = $clog2(MAX_DRUN + 1);
  localparam logic [DRUN_W-1:0] DRUN_MAX = DRUN_W'(MAX_DRUN);

  arb_state_t        state_q, state_d, pick;
  logic [DRUN_W-1:0] drun_q, drun_d;
  logic              mreq_q, mreq_d, mwe_q, mwe_d;
  logic [XLEN-1:0]   maddr_q, maddr_d, mwdata_q, mwdata_d;
  logic [XLEN-1:0]   inst_q, inst_d, drdata_q, drdata_d;
  logic              ivalid_q, ivalid_d, dvalid_q, dvalid_d;

  assign pick = arb_pick(bus.i_dren | bus.i_dwen, bus.i_ireq, drun_q < DRUN_MAX);

  always_comb begin
    state_d  = state_q;
    drun_d   = drun_q;
    mreq_d   = mreq_q;
    mwe_d    = mwe_q;
    maddr_d  = maddr_q;
    mwdata_d = mwdata_q;
    inst_d   = inst_q;
    drdata_d = drdata_q;
    ivalid_d = 1'b0;
    dvalid_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // The requester just completed still shows its old request during its
        // valid pulse, so no arbitration happens in that cycle.
        if (!(ivalid_q || dvalid_q)) begin
          state_d = pick;
          if (pick == ST_DGRANT) begin
            mreq_d   = 1'b1;
            mwe_d    = bus.i_dwen;
            maddr_d  = bus.i_daddr;
            mwdata_d = bus.i_dwdata;
          end else if (pick == ST_IGRANT) begin
            mreq_d   = 1'b1;
            mwe_d    = 1'b0;
            maddr_d  = bus.i_iaddr;
            mwdata_d = '0;
          end
        end
      end
      ST_IGRANT: begin
        if (bus.i_mack) begin
          inst_d   = bus.i_mrdata;
          ivalid_d = 1'b1;
          mreq_d   = 1'b0;
          mwe_d    = 1'b0;
          state_d  = ST_IDLE;
        end
      end
      ST_DGRANT: begin
        if (bus.i_mack) begin
          if (!mwe_q) drdata_d = bus.i_mrdata;
          dvalid_d = 1'b1;
          mreq_d   = 1'b0;
          mwe_d    = 1'b0;
          state_d  = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (!bus.i_ireq || (state_q == ST_IDLE && state_d == ST_IGRANT)) begin
      drun_d = '0;
    end else if (state_q == ST_IDLE && state_d == ST_DGRANT && drun_q < DRUN_MAX) begin
      drun_d = drun_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      drun_q   <= '0;
      mreq_q   <= 1'b0;
      mwe_q    <= 1'b0;
      maddr_q  <= '0;
      mwdata_q <= '0;
      inst_q   <= '0;
      drdata_q <= '0;
      ivalid_q <= 1'b0;
      dvalid_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      drun_q   <= drun_d;
      mreq_q   <= mreq_d;
      mwe_q    <= mwe_d;
      maddr_q  <= maddr_d;
      mwdata_q <= mwdata_d;
      inst_q   <= inst_d;
      drdata_q <= drdata_d;
      ivalid_q <= ivalid_d;
      dvalid_q <= dvalid_d;
    end
  end

  assign bus.o_inst    = inst_q;
  assign bus.o_ivalid  = ivalid_q;
  assign bus.o_drdata  = drdata_q;
  assign bus.o_dvalid  = dvalid_q;
  assign bus.o_mreq    = mreq_q;
  assign bus.o_mwe     = mwe_q;
  assign bus.o_maddr   = maddr_q;
  assign bus.o_mwdata  = mwdata_q;
  assign bus.o_exstall = (bus.i_dren | bus.i_dwen) & ~dvalid_q;
  assign o_state       = state_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed testbench for mem_arbiter: fetch, load, store, priority, starvation
// limit, back-to-back spacing, reset mid-transaction and stray acknowledges.
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] IADDR = 32'h0000_0100;
  localparam logic [XLEN-1:0] DADDR = 32'h0000_3000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mem_arbiter_if #(.XLEN(XLEN)) bus ();
  arb_state_t dbg_state;

  logic            mack_auto;
  logic            mack_force;
  logic [XLEN-1:0] mem_rdata;
  bit              mem_auto;
  int              mem_wait;

  int tests_run;
  int tests_failed;
  int cyc;
  int ivalid_cnt;
  int dvalid_cnt;
  logic [XLEN-1:0] grant_log[$];
  int              grant_cyc[$];
  logic [XLEN-1:0] exp_q[$];

  assign bus.i_mack   = mack_auto | mack_force;
  assign bus.i_mrdata = mem_rdata;

  mem_arbiter #(.XLEN(XLEN), .MAX_DRUN(4)) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus),
    .o_state (dbg_state)
  );

  // Memory model and bus monitor, evaluated 1 time unit after each rising edge.
  initial begin : responder
    int   cnt;
    logic mreq_prev;
    cnt = 0;
    mreq_prev = 1'b0;
    mack_auto = 1'b0;
    cyc = 0;
    ivalid_cnt = 0;
    dvalid_cnt = 0;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (bus.o_ivalid === 1'b1) ivalid_cnt++;
      if (bus.o_dvalid === 1'b1) dvalid_cnt++;
      if (bus.o_mreq === 1'b1 && mreq_prev !== 1'b1) begin
        grant_log.push_back(bus.o_maddr);
        grant_cyc.push_back(cyc);
      end
      mreq_prev = bus.o_mreq;
      mack_auto = 1'b0;
      if (mem_auto && bus.o_mreq === 1'b1) begin
        if (cnt >= mem_wait) begin
          mack_auto = 1'b1;
          cnt = 0;
        end else begin
          cnt++;
        end
      end else begin
        cnt = 0;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    tests_run++;
    if ({bus.o_mreq, bus.o_mwe, bus.o_ivalid, bus.o_dvalid, bus.o_exstall} !== 5'b0) begin
      tests_failed++;
      $display("FAIL reset_ctrl: got %b required 00000",
               {bus.o_mreq, bus.o_mwe, bus.o_ivalid, bus.o_dvalid, bus.o_exstall});
    end
    tests_run++;
    if ({bus.o_inst, bus.o_drdata, bus.o_maddr, bus.o_mwdata} !== '0) begin
      tests_failed++;
      $display("FAIL reset_data: inst=%h drdata=%h maddr=%h mwdata=%h required all 0",
               bus.o_inst, bus.o_drdata, bus.o_maddr, bus.o_mwdata);
    end
    rst = 1'b0;
    step();
    tests_run++;
    if (dbg_state !== ST_IDLE) begin
      tests_failed++;
      $display("FAIL reset_state: got %0d required %0d", dbg_state, ST_IDLE);
    end
  endtask

  task automatic test_idle_fetch();
    int n;
    int base;
    base = ivalid_cnt;
    mem_auto = 1'b1;
    mem_wait = 1;
    mem_rdata = 32'h0000_0013;
    bus.i_ireq = 1'b1;
    bus.i_iaddr = IADDR;
    step();
    tests_run++;
    if (bus.o_mreq !== 1'b1 || bus.o_mwe !== 1'b0 || bus.o_maddr !== IADDR) begin
      tests_failed++;
      $display("FAIL fetch_req: mreq=%b mwe=%b maddr=%h required 1 0 %h",
               bus.o_mreq, bus.o_mwe, bus.o_maddr, IADDR);
    end
    tests_run++;
    if (dbg_state !== ST_IGRANT) begin
      tests_failed++;
      $display("FAIL fetch_state: got %0d required %0d", dbg_state, ST_IGRANT);
    end
    n = 0;
    while (bus.o_ivalid !== 1'b1 && n < 10) begin
      step();
      n++;
    end
    tests_run++;
    if (n !== 2) begin
      tests_failed++;
      $display("FAIL fetch_latency: ivalid after %0d cycles required 2", n);
    end
    tests_run++;
    if (bus.o_inst !== 32'h0000_0013 || bus.o_mreq !== 1'b0) begin
      tests_failed++;
      $display("FAIL fetch_data: inst=%h mreq=%b required 00000013 0", bus.o_inst, bus.o_mreq);
    end
    bus.i_ireq = 1'b0;
    step();
    tests_run++;
    if (bus.o_ivalid !== 1'b0) begin
      tests_failed++;
      $display("FAIL fetch_pulse: ivalid=%b required 0", bus.o_ivalid);
    end
    step();
    step();
    tests_run++;
    if (ivalid_cnt - base !== 1) begin
      tests_failed++;
      $display("FAIL fetch_pulses: got %0d pulses required 1", ivalid_cnt - base);
    end
  endtask

  task automatic test_load();
    mem_auto = 1'b1;
    mem_wait = 0;
    mem_rdata = 32'h1234_5678;
    bus.i_dren = 1'b1;
    bus.i_daddr = DADDR;
    step();
    tests_run++;
    if (bus.o_mreq !== 1'b1 || bus.o_mwe !== 1'b0 || bus.o_maddr !== DADDR) begin
      tests_failed++;
      $display("FAIL load_req: mreq=%b mwe=%b maddr=%h required 1 0 %h",
               bus.o_mreq, bus.o_mwe, bus.o_maddr, DADDR);
    end
    step();
    tests_run++;
    if (bus.o_dvalid !== 1'b1 || bus.o_drdata !== 32'h1234_5678 || bus.o_exstall !== 1'b0) begin
      tests_failed++;
      $display("FAIL load_done: dvalid=%b drdata=%h exstall=%b required 1 12345678 0",
               bus.o_dvalid, bus.o_drdata, bus.o_exstall);
    end
    bus.i_dren = 1'b0;
    step();
    step();
  endtask

  task automatic test_store();
    int n;
    mem_auto = 1'b1;
    mem_wait = 1;
    mem_rdata = 32'hFFFF_FFFF;
    bus.i_dwen = 1'b1;
    bus.i_daddr = 32'h0000_2000;
    bus.i_dwdata = 32'hDEAD_BEEF;
    step();
    tests_run++;
    if (bus.o_mreq !== 1'b1 || bus.o_mwe !== 1'b1 || bus.o_mwdata !== 32'hDEAD_BEEF ||
        bus.o_maddr !== 32'h0000_2000) begin
      tests_failed++;
      $display("FAIL store_req: mreq=%b mwe=%b mwdata=%h maddr=%h required 1 1 deadbeef 00002000",
               bus.o_mreq, bus.o_mwe, bus.o_mwdata, bus.o_maddr);
    end
    n = 0;
    while (bus.o_dvalid !== 1'b1 && n < 10) begin
      tests_run++;
      if (bus.o_exstall !== 1'b1) begin
        tests_failed++;
        $display("FAIL store_stall: exstall=%b at wait %0d required 1", bus.o_exstall, n);
      end
      step();
      n++;
    end
    tests_run++;
    if (bus.o_dvalid !== 1'b1 || bus.o_exstall !== 1'b0) begin
      tests_failed++;
      $display("FAIL store_done: dvalid=%b exstall=%b required 1 0", bus.o_dvalid, bus.o_exstall);
    end
    tests_run++;
    if (bus.o_drdata !== 32'h1234_5678) begin
      tests_failed++;
      $display("FAIL store_drdata: got %h required 12345678", bus.o_drdata);
    end
    bus.i_dwen = 1'b0;
    step();
    step();
  endtask

  task automatic test_simultaneous();
    int dv_at;
    int iv_at;
    mem_auto = 1'b1;
    mem_wait = 0;
    mem_rdata = 32'h0000_0055;
    grant_log.delete();
    exp_q = '{DADDR, IADDR};
    dv_at = -1;
    iv_at = -1;
    bus.i_ireq = 1'b1;
    bus.i_iaddr = IADDR;
    bus.i_dren = 1'b1;
    bus.i_daddr = DADDR;
    for (int i = 0; i < 20 && iv_at < 0; i++) begin
      step();
      if (bus.o_dvalid === 1'b1 && dv_at < 0) begin
        dv_at = i;
        bus.i_dren = 1'b0;
      end
      if (bus.o_ivalid === 1'b1) begin
        iv_at = i;
        bus.i_ireq = 1'b0;
      end
    end
    step();
    step();
    tests_run++;
    if (dv_at < 0 || iv_at <= dv_at) begin
      tests_failed++;
      $display("FAIL simul_order: dvalid at %0d ivalid at %0d required dvalid first", dv_at, iv_at);
    end
    tests_run++;
    if (grant_log.size() !== exp_q.size()) begin
      tests_failed++;
      $display("FAIL simul_grants: got %0d grants required %0d", grant_log.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < grant_log.size(); i++) begin
      tests_run++;
      if (grant_log[i] !== exp_q[i]) begin
        tests_failed++;
        $display("FAIL simul_grant%0d: addr %h required %h", i, grant_log[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_contention();
    mem_auto = 1'b1;
    mem_wait = 0;
    mem_rdata = 32'h0000_0066;
    grant_log.delete();
    grant_cyc.delete();
    exp_q = '{DADDR, DADDR, DADDR, DADDR, IADDR, DADDR, DADDR, DADDR, DADDR, IADDR};
    bus.i_ireq = 1'b1;
    bus.i_iaddr = IADDR;
    bus.i_dren = 1'b1;
    bus.i_daddr = DADDR;
    for (int i = 0; i < 60 && grant_log.size() < 10; i++) step();
    bus.i_ireq = 1'b0;
    bus.i_dren = 1'b0;
    for (int i = 0; i < 4; i++) step();
    tests_run++;
    if (grant_log.size() !== 10) begin
      tests_failed++;
      $display("FAIL contend_count: got %0d grants required 10", grant_log.size());
    end
    for (int i = 0; i < exp_q.size() && i < grant_log.size(); i++) begin
      tests_run++;
      if (grant_log[i] !== exp_q[i]) begin
        tests_failed++;
        $display("FAIL contend_grant%0d: addr %h required %h", i, grant_log[i], exp_q[i]);
      end
    end
    for (int i = 1; i < 10 && i < grant_cyc.size(); i++) begin
      tests_run++;
      if (grant_cyc[i] - grant_cyc[i-1] !== 3) begin
        tests_failed++;
        $display("FAIL back_to_back%0d: spacing %0d cycles required 3", i,
                 grant_cyc[i] - grant_cyc[i-1]);
      end
    end
  endtask

  task automatic test_reset_mid();
    int base;
    mem_auto = 1'b0;
    mem_rdata = 32'h0000_0077;
    bus.i_dren = 1'b1;
    bus.i_daddr = 32'h0000_4000;
    step();
    tests_run++;
    if (bus.o_mreq !== 1'b1 || dbg_state !== ST_DGRANT) begin
      tests_failed++;
      $display("FAIL rstmid_pre: mreq=%b state=%0d required 1 %0d", bus.o_mreq, dbg_state, ST_DGRANT);
    end
    base = dvalid_cnt;
    rst = 1'b1;
    bus.i_dren = 1'b0;
    step();
    rst = 1'b0;
    step();
    mack_force = 1'b1;
    step();
    mack_force = 1'b0;
    step();
    step();
    tests_run++;
    if (dvalid_cnt !== base) begin
      tests_failed++;
      $display("FAIL rstmid_dvalid: got %0d pulses required 0", dvalid_cnt - base);
    end
    tests_run++;
    if ({bus.o_mreq, bus.o_mwe, bus.o_ivalid, bus.o_dvalid} !== 4'b0 ||
        {bus.o_inst, bus.o_drdata, bus.o_maddr, bus.o_mwdata} !== '0) begin
      tests_failed++;
      $display("FAIL rstmid_outs: mreq=%b mwe=%b drdata=%h maddr=%h required all 0",
               bus.o_mreq, bus.o_mwe, bus.o_drdata, bus.o_maddr);
    end
    tests_run++;
    if (dbg_state !== ST_IDLE) begin
      tests_failed++;
      $display("FAIL rstmid_state: got %0d required %0d", dbg_state, ST_IDLE);
    end
  endtask

  task automatic test_stray_mack();
    int ibase;
    int dbase;
    ibase = ivalid_cnt;
    dbase = dvalid_cnt;
    mem_auto = 1'b0;
    mem_rdata = 32'hCAFE_F00D;
    for (int i = 0; i < 4; i++) begin
      mack_force = (i % 2 == 0);
      step();
      tests_run++;
      if (bus.o_mreq !== 1'b0) begin
        tests_failed++;
        $display("FAIL stray_mreq%0d: got %b required 0", i, bus.o_mreq);
      end
    end
    mack_force = 1'b0;
    step();
    step();
    tests_run++;
    if (ivalid_cnt !== ibase || dvalid_cnt !== dbase) begin
      tests_failed++;
      $display("FAIL stray_valid: ivalid pulses %0d dvalid pulses %0d required 0 0",
               ivalid_cnt - ibase, dvalid_cnt - dbase);
    end
    tests_run++;
    if (bus.o_inst !== '0 || bus.o_drdata !== '0 || dbg_state !== ST_IDLE) begin
      tests_failed++;
      $display("FAIL stray_hold: inst=%h drdata=%h state=%0d required 0 0 %0d",
               bus.o_inst, bus.o_drdata, dbg_state, ST_IDLE);
    end
  endtask

  initial begin
    tests_run = 0;
    tests_failed = 0;
    mack_force = 1'b0;
    mem_rdata = '0;
    mem_auto = 1'b0;
    mem_wait = 0;
    bus.i_ireq = 1'b0;
    bus.i_iaddr = '0;
    bus.i_dren = 1'b0;
    bus.i_dwen = 1'b0;
    bus.i_daddr = '0;
    bus.i_dwdata = '0;
    test_reset();
    test_idle_fetch();
    test_load();
    test_store();
    test_simultaneous();
    test_contention();
    test_reset_mid();
    test_stray_mack();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
